// File: rtl/gpsreceiver2_pkg.sv
// gpsreceiver2_pkg
// Shared definitions for the GPS receiver capture path: capture FSM state
// encoding, default bank address width, counter widths and a saturating
// increment helper used by the dropped-byte counter.
package gpsreceiver2_pkg;

    localparam int ADR_W_DEF = 11;
    localparam int OVR_W     = 16;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FILL  = 2'd2,
        ST_STALL = 2'd3
    } cap_state_t;

    // Saturating +1 for the dropped-byte counter; sticks at all-ones.
    function automatic logic [OVR_W-1:0] satInc(input logic [OVR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gpsreceiver2_bankflags.sv
// gpsreceiver2_bankflags
// Ownership flags for the two sample RAM banks. A set bit means the bank
// holds unread data owned by the reader.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : clear both flags (start of a new capture)
//   i_set          : per-bank completion from the writer
//   i_release      : per-bank drain notification from the reader
//   o_full         : current ownership flags
module gpsreceiver2_bankflags
    import gpsreceiver2_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic [1:0] i_set,
    input  logic [1:0] i_release,
    output logic [1:0] o_full
);

    logic [1:0] r_full;

    // Release is applied before set, so a completion landing in the same
    // cycle as a release of that bank leaves the bank marked full. Releasing
    // a bank that is not full has no effect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 2'b00;
        end else if (i_clear) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~i_release) | i_set;
        end
    end

    assign o_full = r_full;

endmodule

// File: rtl/gpsreceiver2_capctl.sv
// gpsreceiver2_capctl
// Capture controller between the RX byte strobe and the ping-pong sample RAM.
// Sequences arm / fill / bank switch / stall / stop, tracks bank ownership,
// pulses per-bank completion and counts bytes dropped while stalled.
// Ports:
//   i_gps_rec_clk, i_gps_rec_rst_n : clock, asynchronous active-low reset
//   i_byte_stb, i_byte_dat         : incoming sample byte strobe and data
//   i_arm, i_abort                 : start / stop capture pulses
//   i_cap_banks                    : banks to capture (0 = continuous)
//   i_bank_release                 : reader drained bank pulses
//   o_buf_adr, o_buf_dat, o_buf_we : registered RAM write port
//   o_bank_full, o_bank_irq        : bank ownership and completion pulses
//   o_done, o_busy, o_overrun      : capture end pulse, activity, drop count
module gpsreceiver2_capctl
    import gpsreceiver2_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF
) (
    input  logic             i_gps_rec_clk,
    input  logic             i_gps_rec_rst_n,
    input  logic             i_byte_stb,
    input  logic [7:0]       i_byte_dat,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_cap_banks,
    input  logic [1:0]       i_bank_release,
    output logic [ADR_W:0]   o_buf_adr,
    output logic [7:0]       o_buf_dat,
    output logic             o_buf_we,
    output logic [1:0]       o_bank_full,
    output logic [1:0]       o_bank_irq,
    output logic             o_done,
    output logic             o_busy,
    output logic [OVR_W-1:0] o_overrun
);

    cap_state_t       r_state;
    cap_state_t       w_nextState;
    logic [ADR_W-1:0] r_ptr;
    logic             r_bank;
    logic [CNT_W-1:0] r_bankCnt;
    logic [CNT_W-1:0] r_capBanks;
    logic [OVR_W-1:0] r_overrun;
    logic [ADR_W:0]   r_bufAdr;
    logic [7:0]       r_bufDat;
    logic             r_bufWe;
    logic [1:0]       r_bankIrq;
    logic             r_done;

    logic             w_accept;
    logic             w_lastByte;
    logic [1:0]       w_complete;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_capHit;
    logic             w_otherFull;
    logic             w_curFull;
    logic             w_drop;
    logic             w_armGo;
    logic             w_done;
    logic [1:0]       w_full;

    // A byte is written in ARMED or FILL unless abort cancels it this cycle.
    assign w_accept   = i_byte_stb && !i_abort &&
                        ((r_state == ST_ARMED) || (r_state == ST_FILL));
    assign w_lastByte = w_accept && (r_ptr == '1);
    assign w_complete = {w_lastByte && r_bank, w_lastByte && !r_bank};
    assign w_cntNext  = r_bankCnt + 1'b1;
    assign w_capHit   = (r_capBanks != '0) && (w_cntNext == r_capBanks);
    assign w_drop     = i_byte_stb && !i_abort && (r_state == ST_STALL);
    assign w_armGo    = i_arm && !i_abort && (r_state == ST_IDLE);

    // The bank we switch into counts as free if the reader releases it in
    // this same cycle, so a coincident release avoids a needless stall.
    assign w_otherFull = r_bank ? (w_full[0] && !i_bank_release[0])
                                : (w_full[1] && !i_bank_release[1]);
    assign w_curFull   = r_bank ? (w_full[1] && i_bank_release[1])
                                : (w_full[0] && i_bank_release[0]);

    // Next-state and done-pulse decode. Abort dominates everything.
    always_comb begin
        w_nextState = r_state;
        w_done      = 1'b0;
        if (i_abort) begin
            w_nextState = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_arm) w_nextState = ST_ARMED;
                end
                ST_ARMED, ST_FILL: begin
                    if (w_accept) begin
                        w_nextState = ST_FILL;
                        if (w_lastByte) begin
                            if (w_capHit) begin
                                w_nextState = ST_IDLE;
                                w_done      = 1'b1;
                            end else if (w_otherFull) begin
                                w_nextState = ST_STALL;
                            end
                        end
                    end
                end
                ST_STALL: begin
                    if (w_curFull) w_nextState = ST_FILL;
                end
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    // State, write port, pointer/bank/counter and overrun registers.
    always_ff @(posedge i_gps_rec_clk or negedge i_gps_rec_rst_n) begin
        if (!i_gps_rec_rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_bank     <= 1'b0;
            r_bankCnt  <= '0;
            r_capBanks <= '0;
            r_overrun  <= '0;
            r_bufAdr   <= '0;
            r_bufDat   <= '0;
            r_bufWe    <= 1'b0;
            r_bankIrq  <= 2'b00;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_bufWe   <= w_accept;
            r_bankIrq <= w_complete;
            r_done    <= w_done;
            if (w_accept) begin
                r_bufAdr <= {r_bank, r_ptr};
                r_bufDat <= i_byte_dat;
            end
            if (w_armGo) begin
                r_ptr      <= '0;
                r_bank     <= 1'b0;
                r_bankCnt  <= '0;
                r_capBanks <= i_cap_banks;
                r_overrun  <= '0;
            end else if (w_accept) begin
                r_ptr <= r_ptr + 1'b1;
                if (w_lastByte) begin
                    r_bank    <= !r_bank;
                    r_bankCnt <= w_cntNext;
                end
            end
            if (w_drop) begin
                r_overrun <= satInc(r_overrun);
            end
        end
    end

    gpsreceiver2_bankflags u_bankflags (
        .i_clk     (i_gps_rec_clk),
        .i_rst_n   (i_gps_rec_rst_n),
        .i_clear   (w_armGo),
        .i_set     (w_complete),
        .i_release (i_bank_release),
        .o_full    (w_full)
    );

    assign o_buf_adr   = r_bufAdr;
    assign o_buf_dat   = r_bufDat;
    assign o_buf_we    = r_bufWe;
    assign o_bank_full = w_full;
    assign o_bank_irq  = r_bankIrq;
    assign o_done      = r_done;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_gpsreceiver2_capctl.sv
// tb_gpsreceiver2_capctl
// Directed bench for the capture controller: reset values, single-bank
// finite capture, continuous fill into stall, release/resume, coincident
// completion and release, abort, arm priority, overrun saturation and
// asynchronous reset mid-capture.
module tb_gpsreceiver2_capctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byteStb = 1'b0;
    logic [7:0]  byteDat = 8'h00;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] capBanks = 16'd0;
    logic [1:0]  bankRelease = 2'b00;
    logic [11:0] bufAdr;
    logic [7:0]  bufDat;
    logic        bufWe;
    logic [1:0]  bankFull;
    logic [1:0]  bankIrq;
    logic        done;
    logic        busy;
    logic [15:0] overrun;

    int errors = 0;
    int checks = 0;

    gpsreceiver2_capctl #(.ADR_W(11)) dut (
        .i_gps_rec_clk   (clk),
        .i_gps_rec_rst_n (rst_n),
        .i_byte_stb      (byteStb),
        .i_byte_dat      (byteDat),
        .i_arm           (arm),
        .i_abort         (abort),
        .i_cap_banks     (capBanks),
        .i_bank_release  (bankRelease),
        .o_buf_adr       (bufAdr),
        .o_buf_dat       (bufDat),
        .o_buf_we        (bufWe),
        .o_bank_full     (bankFull),
        .o_bank_irq      (bankIrq),
        .o_done          (done),
        .o_busy          (busy),
        .o_overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs from a falling edge, wait for the next
    // falling edge (outputs of that rising edge are then stable), and
    // return with every pulse input deasserted.
    task automatic applyStimulus(input logic stb, input logic [7:0] dat,
                                 input logic [1:0] rel, input logic armIn,
                                 input logic abortIn, input logic [15:0] cap);
        byteStb     = stb;
        byteDat     = dat;
        bankRelease = rel;
        arm         = armIn;
        abort       = abortIn;
        capBanks    = cap;
        @(negedge clk);
        byteStb     = 1'b0;
        bankRelease = 2'b00;
        arm         = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bufAdr !== 12'd0 || bufDat !== 8'd0 || bufWe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wrport adr=%0d dat=%0d we=%b required 0/0/0", bufAdr, bufDat, bufWe);
        end
        checks++;
        if (bankFull !== 2'b00 || bankIrq !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_bank full=%b irq=%b required 00/00", bankFull, bankIrq);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || overrun !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_status done=%b busy=%b ovr=%0d required 0/0/0", done, busy, overrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_bank();
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 16'd1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arm_busy got=%b required 1", busy);
        end
        for (int i = 0; i < 2048; i++) begin
            applyStimulus(1'b1, 8'(i), 2'b00, 1'b0, 1'b0, 16'd1);
            checks++;
            if (bufWe !== 1'b1 || bufAdr !== 12'(i) || bufDat !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL single_wr%0d we=%b adr=%0d dat=%0d required 1/%0d/%0d", i, bufWe, bufAdr, bufDat, i, i[7:0]);
            end
            if (i == 2046) begin
                checks++;
                if (bankIrq !== 2'b00 || done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL single_early irq=%b done=%b busy=%b required 00/0/1", bankIrq, done, busy);
                end
            end
        end
        checks++;
        if (bankIrq !== 2'b01 || done !== 1'b1 || busy !== 1'b0 || bankFull !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_end irq=%b done=%b busy=%b full=%b required 01/1/0/01", bankIrq, done, busy, bankFull);
        end
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 16'd1);
        checks++;
        if (done !== 1'b0 || bankIrq !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_pulse done=%b irq=%b required 0/00", done, bankIrq);
        end
    endtask

    task automatic test_continuous_stall();
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 16'd0);
        checks++;
        if (bankFull !== 2'b00 || overrun !== 16'd0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cont_arm full=%b ovr=%0d busy=%b required 00/0/1", bankFull, overrun, busy);
        end
        for (int i = 0; i < 5000; i++) begin
            applyStimulus(1'b1, 8'(i * 3), 2'b00, 1'b0, 1'b0, 16'd0);
            checks++;
            if (i < 4096) begin
                if (bufWe !== 1'b1 || bufAdr !== 12'(i) || bufDat !== 8'(i * 3)) begin
                    errors++;
                    $display("[TB] FAIL cont_wr%0d we=%b adr=%0d dat=%0d required 1/%0d", i, bufWe, bufAdr, bufDat, i);
                end
            end else begin
                if (bufWe !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cont_drop%0d we=%b required 0", i, bufWe);
                end
            end
            if (i == 2047) begin
                checks++;
                if (bankIrq !== 2'b01 || bankFull !== 2'b01 || done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cont_bank0 irq=%b full=%b done=%b required 01/01/0", bankIrq, bankFull, done);
                end
            end
            if (i == 4095) begin
                checks++;
                if (bankIrq !== 2'b10 || bankFull !== 2'b11 || done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cont_bank1 irq=%b full=%b done=%b required 10/11/0", bankIrq, bankFull, done);
                end
            end
        end
        checks++;
        if (overrun !== 16'd904 || busy !== 1'b1 || bankFull !== 2'b11) begin
            errors++;
            $display("[TB] FAIL cont_stall ovr=%0d busy=%b full=%b required 904/1/11", overrun, busy, bankFull);
        end
    endtask

    task automatic test_release_resume();
        applyStimulus(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 16'd0);
        checks++;
        if (bankFull !== 2'b10 || bufWe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rel_flags full=%b we=%b required 10/0", bankFull, bufWe);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 2'b00, 1'b0, 1'b0, 16'd0);
            checks++;
            if (bufWe !== 1'b1 || bufAdr !== 12'(i) || bufDat !== 8'(8'hA0 + i)) begin
                errors++;
                $display("[TB] FAIL rel_wr%0d we=%b adr=%0d dat=%h required 1/%0d", i, bufWe, bufAdr, bufDat, i);
            end
        end
        checks++;
        if (bankFull !== 2'b10 || overrun !== 16'd904) begin
            errors++;
            $display("[TB] FAIL rel_after full=%b ovr=%0d required 10/904", bankFull, overrun);
        end
    endtask

    task automatic test_release_collide();
        for (int p = 3; p < 2048; p++) begin
            applyStimulus(1'b1, 8'(p), (p == 2047) ? 2'b10 : 2'b00, 1'b0, 1'b0, 16'd0);
            checks++;
            if (bufWe !== 1'b1 || bufAdr !== 12'(p)) begin
                errors++;
                $display("[TB] FAIL coll_wr%0d we=%b adr=%0d required 1/%0d", p, bufWe, bufAdr, p);
            end
        end
        checks++;
        if (bankFull !== 2'b01 || bankIrq !== 2'b01) begin
            errors++;
            $display("[TB] FAIL coll_flags full=%b irq=%b required 01/01", bankFull, bankIrq);
        end
        applyStimulus(1'b1, 8'h5A, 2'b00, 1'b0, 1'b0, 16'd0);
        checks++;
        if (bufWe !== 1'b1 || bufAdr !== 12'd2048 || bufDat !== 8'h5A || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL coll_next we=%b adr=%0d dat=%h busy=%b required 1/2048/5a/1", bufWe, bufAdr, bufDat, busy);
        end
    endtask

    task automatic test_abort();
        for (int k = 1; k < 100; k++) begin
            applyStimulus(1'b1, 8'(k), 2'b00, 1'b0, 1'b0, 16'd0);
            checks++;
            if (bufWe !== 1'b1 || bufAdr !== 12'(2048 + k)) begin
                errors++;
                $display("[TB] FAIL abort_pre%0d we=%b adr=%0d required 1/%0d", k, bufWe, bufAdr, 2048 + k);
            end
        end
        applyStimulus(1'b1, 8'hEE, 2'b00, 1'b0, 1'b1, 16'd0);
        checks++;
        if (bufWe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bankFull !== 2'b01) begin
            errors++;
            $display("[TB] FAIL abort_stop we=%b busy=%b done=%b full=%b required 0/0/0/01", bufWe, busy, done, bankFull);
        end
        applyStimulus(1'b1, 8'h11, 2'b00, 1'b0, 1'b0, 16'd0);
        checks++;
        if (bufWe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_nowrite we=%b required 0", bufWe);
        end
    endtask

    task automatic test_arm_priority();
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 16'd0);
        checks++;
        if (busy !== 1'b0 || bankFull !== 2'b01) begin
            errors++;
            $display("[TB] FAIL arm_vs_abort busy=%b full=%b required 0/01", busy, bankFull);
        end
    endtask

    task automatic test_overrun_saturation();
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 4096; i++) begin
            applyStimulus(1'b1, 8'(i), 2'b00, 1'b0, 1'b0, 16'd0);
        end
        checks++;
        if (bankFull !== 2'b11 || busy !== 1'b1 || overrun !== 16'd0) begin
            errors++;
            $display("[TB] FAIL sat_stall full=%b busy=%b ovr=%0d required 11/1/0", bankFull, busy, overrun);
        end
        force dut.r_overrun = 16'hFFFE;
        @(negedge clk);
        release dut.r_overrun;
        applyStimulus(1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 16'd0);
        checks++;
        if (overrun !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL sat_first ovr=%h required ffff", overrun);
        end
        applyStimulus(1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 16'd0);
        applyStimulus(1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 16'd0);
        checks++;
        if (overrun !== 16'hFFFF || bufWe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_hold ovr=%h we=%b required ffff/0", overrun, bufWe);
        end
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 16'd0);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 16'd0);
        checks++;
        if (overrun !== 16'd0 || busy !== 1'b1 || bankFull !== 2'b00) begin
            errors++;
            $display("[TB] FAIL sat_rearm ovr=%h busy=%b full=%b required 0/1/00", overrun, busy, bankFull);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 2'b00, 1'b0, 1'b0, 16'd0);
        end
        checks++;
        if (bufWe !== 1'b1 || bufAdr !== 12'd9 || bufDat !== 8'd10) begin
            errors++;
            $display("[TB] FAIL ares_pre we=%b adr=%0d dat=%0d required 1/9/10", bufWe, bufAdr, bufDat);
        end
        byteStb = 1'b1;
        byteDat = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bufWe !== 1'b0 || bufAdr !== 12'd0 || bufDat !== 8'd0 || busy !== 1'b0 || overrun !== 16'd0) begin
            errors++;
            $display("[TB] FAIL ares_now we=%b adr=%0d dat=%0d busy=%b ovr=%0d required all 0", bufWe, bufAdr, bufDat, busy, overrun);
        end
        @(negedge clk);
        byteStb = 1'b0;
        checks++;
        if (bufWe !== 1'b0 || bankFull !== 2'b00 || bankIrq !== 2'b00 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ares_hold we=%b full=%b irq=%b done=%b required 0/00/00/0", bufWe, bankFull, bankIrq, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Scenarios run in order; each builds on the state left by the previous.
    initial begin
        test_reset();
        test_single_bank();
        test_continuous_stall();
        test_release_resume();
        test_release_collide();
        test_abort();
        test_arm_priority();
        test_overrun_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpsreceiver2_capctl.md
# gpsreceiver2_capctl

Capture controller for the GPS receiver sample buffer. Sits between the RX deserializer's byte strobe and the 2-bank (ping-pong) sample RAM. It sequences arm, fill, bank switch, stall and stop, and tracks bank ownership between the RX writer and the CPU reader. It raises per-bank completion pulses and counts dropped bytes when the reader falls behind.

## Interface
Parameters:
- ADR_W, 11, log2 of bank depth in bytes; the buffer holds 2×2^ADR_W bytes.

Ports:
- gps_rec_clk  in  1  sole clock; all logic on its rising edge.
- gps_rec_rst_n  in  1  reset, asynchronous, active-low.
- byte_stb  in  1  one-cycle strobe: byte_dat holds a new {hi,lo} IQ byte.
- byte_dat  in  8  sample byte.
- arm  in  1  pulse; start a capture from IDLE.
- abort  in  1  pulse; stop capture immediately.
- cap_banks  in  16  number of banks to capture; 0 = continuous; sampled at arm.
- bank_release  in  2  pulse per bank; reader has drained that bank.
- buf_adr  out  ADR_W+1  RAM write address {bank, ptr}.
- buf_dat  out  8  RAM write data.
- buf_we  out  1  RAM write enable.
- bank_full  out  2  bank holds unread data.
- bank_irq  out  2  one-cycle pulse when a bank completes.
- done  out  1  one-cycle pulse when a finite capture ends.
- busy  out  1  state != IDLE.
- overrun  out  16  dropped-byte count, saturating at 16'hFFFF.

## Operation
- States:
  - IDLE: arm -> ARMED; clears bank_full, overrun, ptr, bank=0, bank counter; latches cap_banks.
  - ARMED: first byte_stb is written at {0,0} -> FILL. ARMED exists so an arm between bytes never writes a partial byte.
  - FILL: each byte_stb writes at {bank,ptr}, then ptr++.
    - Write at ptr=all-ones completes the bank: bank_full[bank] set, bank_irq[bank] pulses, bank toggles, ptr wraps to 0, bank counter ++.
    - If counter == cap_banks (nonzero) -> IDLE with done pulse.
    - Else if the new bank is full -> STALL.
    - Else stay in FILL.
  - STALL: each byte_stb is dropped and overrun ++ (saturating). bank_release of the current bank -> FILL; the next byte goes to ptr 0.
- bank_release[b] clears bank_full[b] only if it is set; otherwise it is ignored. A release of the bank being written is impossible (that bank is never full) and is ignored.
- Completion and release of the other bank in the same cycle: release is applied first, so the next state is FILL, not STALL.
- Completion of bank b and release of b in the same cycle: the set wins.
- Simultaneous release of both banks is permitted.
- abort in any state -> IDLE next cycle. The byte on the same cycle is not written, bank_full is preserved, and done does not pulse.
- abort wins over arm. arm outside IDLE is ignored.
- Bank counter is 16 bits; in continuous mode it wraps silently.

## Timing
- Reset values: buf_adr=0, buf_dat=0, buf_we=0, bank_full=0, bank_irq=0, done=0, busy=0, overrun=0, state=IDLE.
- Write port is registered: byte_stb in cycle n -> buf_we/buf_adr/buf_dat valid in cycle n+1, for exactly one cycle.
- bank_irq and bank_full update in cycle n+1, the same cycle as the last write of the bank.
- done pulses in cycle n+1 alongside the final write; busy deasserts in that same cycle.
- byte_stb may assert on consecutive cycles; sustained throughput is one byte per cycle, with no bubbles at a bank switch.
- bank_release takes effect on bank_full one cycle later. A byte_stb in the release cycle while in STALL is still dropped.
- Asynchronous reset mid-capture returns all outputs to reset values immediately; no write completes.

## Structure
- Shared package gpsreceiver2_pkg: state encoding (IDLE=0, ARMED=1, FILL=2, STALL=3), ADR_W default, overrun width.
- No sub-module is needed.
- The bank-ownership flags plus set/clear arbitration are small and natural to isolate as gpsreceiver2_bankflags, which the CSR block also reuses for read-side status.

## Test plan
- Reset, arm, cap_banks=1, 2048 back-to-back strobes -> writes at adr 0..2047 with data echoed; bank_irq=2'b01 and done pulse on the last write; busy=0; bank_full=2'b01.
- cap_banks=0, no releases, 5000 strobes -> banks 0 and 1 fill; STALL; overrun=5000-4096=904; buf_we never asserts after adr 4095.
- From the previous STALL, pulse bank_release=2'b01, then send 3 strobes -> writes at adr 0,1,2; bank_full=2'b10; overrun holds at 904.
- Completion of bank 0 with bank_release=2'b10 in the same cycle (bank 1 previously full) -> state FILL, next byte at adr 2048, bank_full=2'b01.
- abort mid-bank at ptr 100 with a coincident strobe -> no write that cycle, busy=0 next cycle, no done, bank_full unchanged.
- Force overrun to 16'hFFFE, then send 3 dropped bytes -> overrun saturates at 16'hFFFF; arm from IDLE clears it to 0.
